layer_ram_engine: RTL and testbench

- Responder side of the network controller's RAM start/done handshake.
- On each start, computes one fully connected layer of N neurons × N inputs: reads activations and weights from the shared single-port RAM, multiply-accumulates, applies activation/saturation, writes N results back, then pulses done.
- Sits between the network controller and the weight/activation RAM.

---
 rtl/layer_ram_engine_if.sv | 22 ++
 rtl/layer_ram_engine.sv | 167 ++++++++++++++++
 tb/tb_layer_ram_engine.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/layer_ram_engine_if.sv
// Single-port weight/activation RAM bus between layer_ram_engine (master) and the RAM (slave).
// Read data is registered in the RAM: valid the cycle after ram_rd_en.
interface layer_ram_engine_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8
);
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_rd_en;
  logic [DATA_W-1:0] ram_rdata;
  logic              ram_wr_en;
  logic [DATA_W-1:0] ram_wdata;

  modport master (
    output ram_addr, ram_rd_en, ram_wr_en, ram_wdata,
    input  ram_rdata
  );

  modport slave (
    input  ram_addr, ram_rd_en, ram_wr_en, ram_wdata,
    output ram_rdata
  );
endinterface

// File: rtl/layer_ram_engine.sv
// One fully connected layer per start: N x N MAC over shared RAM, ReLU/saturate, write back, pulse done.
// Optional per-neuron bias preload is enabled with `define LAYER_RAM_BIAS_EN.
module layer_ram_engine #(
  parameter int N        = 4,
  parameter int DATA_W   = 8,
  parameter int FRAC     = 4,
  parameter int ACC_W    = 20,
  parameter int ADDR_W   = 10,
  parameter int ACT_BASE = 0,
  parameter int W_BASE   = 64,
  parameter int B_BASE   = 128
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [1:0]          layer,
  input  logic                layer_sel,
  output logic                done,
  output logic                busy,
  layer_ram_engine_if.master  ram
);
  localparam int IW = $clog2(N);

  if (ACC_W < 2*DATA_W + IW) begin : g_acc_chk
    $error("layer_ram_engine: ACC_W too narrow for N products");
  end
  if (W_BASE + 4*N*N > (1 << ADDR_W) || B_BASE + 4*N > (1 << ADDR_W)) begin : g_addr_chk
    $error("layer_ram_engine: weight/bias region exceeds address space");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_RD_B, S_LD_B, S_RD_X, S_RD_W, S_MAC, S_WRITE, S_DONE
  } state_t;

`ifdef LAYER_RAM_BIAS_EN
  localparam state_t NEURON_FIRST = S_RD_B;
`else
  localparam state_t NEURON_FIRST = S_RD_X;
`endif

  localparam logic [IW-1:0]     LAST  = IW'(N-1);
  localparam logic [ADDR_W-1:0] A_N   = ADDR_W'(N);
  localparam logic [ADDR_W-1:0] A_ACT = ADDR_W'(ACT_BASE);
  localparam logic [ADDR_W-1:0] A_W   = ADDR_W'(W_BASE);
  localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'((1 << (DATA_W-1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_LO = ~SAT_HI;

  state_t                    state, state_nxt;
  logic [1:0]                lyr;
  logic                      sel;
  logic [IW-1:0]             i_cnt, j_cnt;
  logic [DATA_W-1:0]         x_reg;
  logic signed [ACC_W-1:0]   acc;

  // Address generation from latched layer and running neuron/input counters
  logic [ADDR_W-1:0] l_off, x_addr, w_addr, o_addr;
  assign l_off  = ADDR_W'(lyr) * A_N;
  assign x_addr = A_ACT + l_off + ADDR_W'(i_cnt);
  assign o_addr = A_ACT + l_off + A_N + ADDR_W'(j_cnt);
  assign w_addr = A_W + l_off * A_N + ADDR_W'(j_cnt) * A_N + ADDR_W'(i_cnt);

`ifdef LAYER_RAM_BIAS_EN
  localparam logic [ADDR_W-1:0] A_B = ADDR_W'(B_BASE);
  logic [ADDR_W-1:0]       b_addr;
  logic signed [ACC_W-1:0] bias_ext;
  assign b_addr   = A_B + l_off + ADDR_W'(j_cnt);
  assign bias_ext = {{(ACC_W-DATA_W){ram.ram_rdata[DATA_W-1]}}, ram.ram_rdata};
`endif

  // MAC: x was latched in RD_W, weight arrives on rdata during MAC
  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    acc_mac;
  assign prod    = $signed(x_reg) * $signed(ram.ram_rdata);
  assign acc_mac = acc + {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};

  logic signed [ACC_W-1:0] scaled;
  logic [DATA_W-1:0]       sat_val;
  assign scaled = acc >>> FRAC;

  always_comb begin
    sat_val = scaled[DATA_W-1:0];
    if (!sel && scaled[ACC_W-1])  sat_val = '0;
    else if (scaled > SAT_HI)     sat_val = SAT_HI[DATA_W-1:0];
    else if (scaled < SAT_LO)     sat_val = SAT_LO[DATA_W-1:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    ram.ram_addr  = '0;
    ram.ram_rd_en = 1'b0;
    ram.ram_wr_en = 1'b0;
    ram.ram_wdata = '0;
    case (state)
      S_IDLE: if (start) state_nxt = NEURON_FIRST;
`ifdef LAYER_RAM_BIAS_EN
      S_RD_B: begin
        ram.ram_addr  = b_addr;
        ram.ram_rd_en = 1'b1;
        state_nxt     = S_LD_B;
      end
      S_LD_B: state_nxt = S_RD_X;
`endif
      S_RD_X: begin
        ram.ram_addr  = x_addr;
        ram.ram_rd_en = 1'b1;
        state_nxt     = S_RD_W;
      end
      S_RD_W: begin
        ram.ram_addr  = w_addr;
        ram.ram_rd_en = 1'b1;
        state_nxt     = S_MAC;
      end
      S_MAC:   state_nxt = (i_cnt == LAST) ? S_WRITE : S_RD_X;
      S_WRITE: begin
        ram.ram_addr  = o_addr;
        ram.ram_wr_en = 1'b1;
        ram.ram_wdata = sat_val;
        state_nxt     = (j_cnt == LAST) ? S_DONE : NEURON_FIRST;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lyr   <= '0;
      sel   <= 1'b0;
      i_cnt <= '0;
      j_cnt <= '0;
      x_reg <= '0;
      acc   <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          lyr   <= layer;
          sel   <= layer_sel;
          acc   <= '0;
          i_cnt <= '0;
          j_cnt <= '0;
        end
`ifdef LAYER_RAM_BIAS_EN
        S_LD_B: acc <= bias_ext <<< FRAC;
`endif
        S_RD_W: x_reg <= ram.ram_rdata;
        S_MAC: begin
          acc <= acc_mac;
          if (i_cnt != LAST) i_cnt <= i_cnt + 1'b1;
        end
        S_WRITE: if (j_cnt != LAST) begin
          j_cnt <= j_cnt + 1'b1;
          i_cnt <= '0;
          acc   <= '0;
        end
        default: ;
      endcase
    end
  end

  assign done = (state == S_DONE);
  assign busy = (state != S_IDLE) && (state != S_DONE);
endmodule

// File: tb/tb_layer_ram_engine.sv
// Directed bench for layer_ram_engine: RAM model, per-scenario tasks with inline checks.
module tb_layer_ram_engine;
  localparam int N = 4, DATA_W = 8, FRAC = 4, ACC_W = 20, ADDR_W = 10;
  localparam int ACT_BASE = 0, W_BASE = 64, B_BASE = 128;
`ifdef LAYER_RAM_BIAS_EN
  localparam int               LAT     = N*(3*N+3)+1;
  localparam logic [7:0]       EXP_ID  = 8'd12;
  localparam logic [7:0]       EXP_NEG = 8'hF8;
  localparam logic [7:0]       BIAS    = 8'd2;
  localparam logic [3:0][7:0]  EXP_CHAIN = {8'd127, 8'd127, 8'd50, 8'd12};
`else
  localparam int               LAT     = N*(3*N+1)+1;
  localparam logic [7:0]       EXP_ID  = 8'd10;
  localparam logic [7:0]       EXP_NEG = 8'hF6;
  localparam logic [7:0]       BIAS    = 8'd0;
  localparam logic [3:0][7:0]  EXP_CHAIN = {8'd127, 8'd127, 8'd40, 8'd10};
`endif

  logic clk, reset, start, layer_sel, done, busy;
  logic [1:0] layer;

  layer_ram_engine_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) ram_if ();

  layer_ram_engine #(
    .N(N), .DATA_W(DATA_W), .FRAC(FRAC), .ACC_W(ACC_W), .ADDR_W(ADDR_W),
    .ACT_BASE(ACT_BASE), .W_BASE(W_BASE), .B_BASE(B_BASE)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .layer(layer), .layer_sel(layer_sel),
    .done(done), .busy(busy), .ram(ram_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM contents are written only by the stimulus process; reads are registered
  logic [7:0] mem [1024];
  always @(posedge clk) if (ram_if.ram_rd_en) ram_if.ram_rdata <= mem[ram_if.ram_addr];

  int n_checks = 0, n_pass = 0;
  int done_cyc, ndone, nwr, collide, w_oob, b_touch, idle_bad, busy_bad, wr_after_rst;
  logic [ADDR_W-1:0] wr_addr [16];
  logic [7:0]        wr_data [16];

  task automatic fill(input int base, input int cnt, input logic [7:0] v);
    for (int k = 0; k < cnt; k++) mem[base+k] = v;
  endtask

  // Starts a run and watches the bus for win cycles after the start-sampling edge
  task automatic run_layer(input logic [1:0] l, input logic sel, input int pulse_cyc,
                           input int rst_cyc, input int win);
    int a;
    done_cyc = 0; ndone = 0; nwr = 0; collide = 0; w_oob = 0; b_touch = 0;
    idle_bad = 0; busy_bad = 0; wr_after_rst = 0;
    @(negedge clk);
    layer = l; layer_sel = sel; start = 1'b1;
    @(posedge clk);
    for (int cyc = 1; cyc <= win; cyc++) begin
      @(negedge clk);
      if (cyc == 1) start = 1'b0;
      a = int'(ram_if.ram_addr);
      if (ram_if.ram_rd_en && ram_if.ram_wr_en) collide++;
      if (ram_if.ram_wr_en) begin
        if (nwr < 16) begin
          wr_addr[nwr] = ram_if.ram_addr;
          wr_data[nwr] = ram_if.ram_wdata;
        end
        nwr++;
        mem[a] = ram_if.ram_wdata;
        if (rst_cyc > 0 && cyc > rst_cyc) wr_after_rst++;
      end
      if (ram_if.ram_rd_en && a >= W_BASE && a < B_BASE &&
          (a < W_BASE + 16*int'(l) || a >= W_BASE + 16*int'(l) + 16)) w_oob++;
`ifndef LAYER_RAM_BIAS_EN
      if ((ram_if.ram_rd_en || ram_if.ram_wr_en) && a >= B_BASE) b_touch++;
`endif
      if (done) begin
        ndone++;
        if (done_cyc == 0) done_cyc = cyc;
        if (busy || ram_if.ram_rd_en || ram_if.ram_wr_en || a != 0) idle_bad++;
      end else if (rst_cyc == 0 && ndone == 0 && !busy) busy_bad++;
      else if (ndone > 0 && busy) busy_bad++;
      if (pulse_cyc > 0 && cyc == pulse_cyc) start = 1'b1;
      if (pulse_cyc > 0 && cyc == pulse_cyc + 1) start = 1'b0;
      if (rst_cyc > 0 && cyc == rst_cyc) reset = 1'b0;
      if (rst_cyc > 0 && cyc == rst_cyc + 3) reset = 1'b1;
    end
  endtask

  task automatic test_reset();
    #2 reset = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if (done !== 1'b0) $display("FAIL rst_done got %b want 0", done); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL rst_busy got %b want 0", busy); else n_pass++;
    n_checks++; if (ram_if.ram_addr !== '0) $display("FAIL rst_addr got %0h want 0", ram_if.ram_addr); else n_pass++;
    n_checks++; if (ram_if.ram_rd_en !== 1'b0) $display("FAIL rst_rd_en got %b want 0", ram_if.ram_rd_en); else n_pass++;
    n_checks++; if (ram_if.ram_wr_en !== 1'b0) $display("FAIL rst_wr_en got %b want 0", ram_if.ram_wr_en); else n_pass++;
    n_checks++; if (ram_if.ram_wdata !== '0) $display("FAIL rst_wdata got %0h want 0", ram_if.ram_wdata); else n_pass++;
    @(negedge clk); reset = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_identity();
    for (int k = 0; k < N; k++) mem[ACT_BASE+k] = 8'(k+1);
    fill(W_BASE, 16, 8'd16);
    run_layer(2'd0, 1'b1, 0, 0, LAT+10);
    n_checks++; if (done_cyc !== LAT) $display("FAIL id_done_cycle got %0d want %0d", done_cyc, LAT); else n_pass++;
    n_checks++; if (ndone !== 1) $display("FAIL id_done_count got %0d want 1", ndone); else n_pass++;
    n_checks++; if (nwr !== N) $display("FAIL id_write_count got %0d want %0d", nwr, N); else n_pass++;
    n_checks++; if (collide !== 0) $display("FAIL id_rd_wr_overlap got %0d want 0", collide); else n_pass++;
    n_checks++; if (busy_bad !== 0) $display("FAIL id_busy_window got %0d bad cycles want 0", busy_bad); else n_pass++;
    n_checks++; if (idle_bad !== 0) $display("FAIL id_done_cycle_bus got %0d want 0", idle_bad); else n_pass++;
    n_checks++; if (w_oob !== 0) $display("FAIL id_weight_range got %0d want 0", w_oob); else n_pass++;
    n_checks++; if (b_touch !== 0) $display("FAIL id_bias_region got %0d want 0", b_touch); else n_pass++;
    for (int j = 0; j < N; j++) begin
      n_checks++; if (wr_addr[j] !== ADDR_W'(ACT_BASE+N+j)) $display("FAIL id_addr[%0d] got %0d want %0d", j, wr_addr[j], ACT_BASE+N+j); else n_pass++;
      n_checks++; if (wr_data[j] !== EXP_ID) $display("FAIL id_data[%0d] got %0h want %0h", j, wr_data[j], EXP_ID); else n_pass++;
    end
  endtask

  task automatic test_neg_weights();
    for (int k = 0; k < N; k++) mem[ACT_BASE+k] = 8'(k+1);
    fill(W_BASE, 16, 8'hF0);
    run_layer(2'd0, 1'b0, 0, 0, LAT+10);
    for (int j = 0; j < N; j++) begin
      n_checks++; if (wr_data[j] !== 8'h00) $display("FAIL relu_data[%0d] got %0h want 00", j, wr_data[j]); else n_pass++;
    end
    run_layer(2'd0, 1'b1, 0, 0, LAT+10);
    for (int j = 0; j < N; j++) begin
      n_checks++; if (wr_data[j] !== EXP_NEG) $display("FAIL neg_data[%0d] got %0h want %0h", j, wr_data[j], EXP_NEG); else n_pass++;
    end
  endtask

  task automatic test_saturation();
    fill(ACT_BASE+N, N, 8'd127);
    fill(W_BASE+16, 16, 8'd127);
    run_layer(2'd1, 1'b0, 0, 0, LAT+10);
    for (int j = 0; j < N; j++) begin
      n_checks++; if (wr_addr[j] !== ADDR_W'(ACT_BASE+2*N+j)) $display("FAIL sat_addr[%0d] got %0d want %0d", j, wr_addr[j], ACT_BASE+2*N+j); else n_pass++;
      n_checks++; if (wr_data[j] !== 8'h7F) $display("FAIL sat_pos[%0d] got %0h want 7f", j, wr_data[j]); else n_pass++;
    end
    fill(W_BASE+16, 16, 8'h80);
    run_layer(2'd1, 1'b1, 0, 0, LAT+10);
    for (int j = 0; j < N; j++) begin
      n_checks++; if (wr_data[j] !== 8'h80) $display("FAIL sat_neg[%0d] got %0h want 80", j, wr_data[j]); else n_pass++;
    end
  endtask

  task automatic test_start_while_busy();
    for (int k = 0; k < N; k++) mem[ACT_BASE+k] = 8'(k+1);
    fill(W_BASE, 16, 8'd16);
    run_layer(2'd0, 1'b1, 20, 0, LAT+10);
    n_checks++; if (ndone !== 1) $display("FAIL busy_start_done_count got %0d want 1", ndone); else n_pass++;
    n_checks++; if (nwr !== N) $display("FAIL busy_start_writes got %0d want %0d", nwr, N); else n_pass++;
    n_checks++; if (done_cyc !== LAT) $display("FAIL busy_start_done_cycle got %0d want %0d", done_cyc, LAT); else n_pass++;
  endtask

  task automatic test_reset_mid_run();
    run_layer(2'd0, 1'b1, 0, 30, LAT+20);
    n_checks++; if (wr_after_rst !== 0) $display("FAIL midrst_writes got %0d want 0", wr_after_rst); else n_pass++;
    n_checks++; if (ndone !== 0) $display("FAIL midrst_done got %0d want 0", ndone); else n_pass++;
    run_layer(2'd0, 1'b1, 0, 0, LAT+10);
    n_checks++; if (done_cyc !== LAT) $display("FAIL midrst_rerun_cycle got %0d want %0d", done_cyc, LAT); else n_pass++;
    n_checks++; if (nwr !== N) $display("FAIL midrst_rerun_writes got %0d want %0d", nwr, N); else n_pass++;
    n_checks++; if (wr_data[N-1] !== EXP_ID) $display("FAIL midrst_rerun_data got %0h want %0h", wr_data[N-1], EXP_ID); else n_pass++;
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < N; k++) mem[ACT_BASE+k] = 8'(k+1);
    fill(W_BASE, 64, 8'd16);
    for (int l = 0; l < 4; l++) begin
      run_layer(2'(l), 1'b0, 0, 0, LAT+10);
      n_checks++; if (ndone !== 1) $display("FAIL chain%0d_done got %0d want 1", l, ndone); else n_pass++;
      n_checks++; if (w_oob !== 0) $display("FAIL chain%0d_weight_range got %0d want 0", l, w_oob); else n_pass++;
      for (int j = 0; j < N; j++) begin
        n_checks++; if (wr_addr[j] !== ADDR_W'(ACT_BASE+(l+1)*N+j)) $display("FAIL chain%0d_addr[%0d] got %0d want %0d", l, j, wr_addr[j], ACT_BASE+(l+1)*N+j); else n_pass++;
        n_checks++; if (wr_data[j] !== EXP_CHAIN[l]) $display("FAIL chain%0d_data[%0d] got %0h want %0h", l, j, wr_data[j], EXP_CHAIN[l]); else n_pass++;
      end
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; layer = '0; layer_sel = 1'b0;
    for (int k = 0; k < 1024; k++) mem[k] = 8'h00;
    fill(B_BASE, 16, BIAS);
    test_reset();
    test_identity();
    test_neg_weights();
    test_saturation();
    test_start_while_busy();
    test_reset_mid_run();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
